alu_key_loader: RTL

Operand/opcode loader feeding the 8-bit ALU stage. Walks the operator through loading A, B and the opcode from the 8-bit switch bank with two push keys. Issues a one-cycle ENA strobe, waits for the ALU's registered result, then captures it for the display stage. Sits between board I/O (SW, KEY) and the ALU's RGA/RGB/OPT/ENA/RGZ ports.

---
 rtl/alu_defs.sv | 18 +
 rtl/key_cond.sv | 68 ++++++
 rtl/alu_key_loader.sv | 107 ++++++++++
 3 files changed

// File: rtl/alu_defs.sv
// Shared definitions for the ALU front end: state codes and datapath widths
// used by the key loader, the ALU and the display stage.
package alu_defs;

  localparam int DATA_W  = 8;
  localparam int OP_W    = 4;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_LOAD_OP = 3'd2,
    S_ISSUE   = 3'd3,
    S_WAIT    = 3'd4,
    S_SHOW    = 3'd5
  } state_t;

endpackage

// File: rtl/key_cond.sv
// One push key: 2-flop synchronizer, optional debounce (KEY_DEBOUNCE_EN),
// then a registered one-cycle pulse on each rising edge of the stable value.
module key_cond #(
  parameter int DB_LIMIT = 500000,
  parameter int DB_CNT_W = 20
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_prs
);

  logic r_sync_p0;
  logic r_sync_p1;
  logic r_stable_d;
  logic r_prs;
  logic w_stable;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= i_key;
      r_sync_p1 <= r_sync_p0;
    end
  end

`ifdef KEY_DEBOUNCE_EN
  logic [DB_CNT_W-1:0] r_cnt;
  logic                r_stable;

  // A change is accepted only after DB_LIMIT consecutive differing samples.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (r_sync_p1 == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == DB_CNT_W'(DB_LIMIT - 1)) begin
      r_stable <= r_sync_p1;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_stable = r_stable;
`else
  logic w_unused_db;

  assign w_stable    = r_sync_p1;
  assign w_unused_db = (DB_LIMIT != 0) ^ (DB_CNT_W != 0);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stable_d <= 1'b0;
      r_prs      <= 1'b0;
    end else begin
      r_stable_d <= w_stable;
      r_prs      <= w_stable & ~r_stable_d;
    end
  end

  assign o_prs = r_prs;

endmodule

// File: rtl/alu_key_loader.sv
// Operand/opcode loader for the 8-bit ALU: key-driven FSM, operand registers,
// ENA strobe and result capture. Key debounce enabled by KEY_DEBOUNCE_EN.
module alu_key_loader
  import alu_defs::*;
#(
  parameter int DB_LIMIT = 500000,
  parameter int DB_CNT_W = 20,
  parameter int WAIT_CYC = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] SW,
  input  logic [1:0] KEY,
  input  logic [7:0] RGZ,
  output logic [7:0] RGA,
  output logic [7:0] RGB,
  output logic [3:0] OPT,
  output logic       ENA,
  output logic [7:0] RES,
  output logic [2:0] STATE
);

  localparam int WCNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_rga;
  logic [DATA_W-1:0]   r_rgb;
  logic [DATA_W-1:0]   r_res;
  logic [OP_W-1:0]     r_opt;
  logic                r_ena;
  logic [WCNT_W-1:0]   r_wcnt;
  logic                w_prs0;
  logic                w_prs1;
  logic                w_ld_a;
  logic                w_ld_b;
  logic                w_ld_op;
  logic                w_cap;

  key_cond #(.DB_LIMIT(DB_LIMIT), .DB_CNT_W(DB_CNT_W)) u_key_adv (
    .i_clk (CLK),
    .i_rst (RST),
    .i_key (KEY[0]),
    .o_prs (w_prs0)
  );

  key_cond #(.DB_LIMIT(DB_LIMIT), .DB_CNT_W(DB_CNT_W)) u_key_cancel (
    .i_clk (CLK),
    .i_rst (RST),
    .i_key (KEY[1]),
    .o_prs (w_prs1)
  );

  // Cancel beats advance everywhere except S_WAIT, where the operation must finish.
  always_comb begin
    w_next  = r_state;
    w_ld_a  = 1'b0;
    w_ld_b  = 1'b0;
    w_ld_op = 1'b0;
    w_cap   = 1'b0;
    if (w_prs1 && (r_state != S_WAIT)) begin
      w_next = S_LOAD_A;
    end else begin
      case (r_state)
        S_LOAD_A:  if (w_prs0) begin w_ld_a  = 1'b1; w_next = S_LOAD_B;  end
        S_LOAD_B:  if (w_prs0) begin w_ld_b  = 1'b1; w_next = S_LOAD_OP; end
        S_LOAD_OP: if (w_prs0) begin w_ld_op = 1'b1; w_next = S_ISSUE;   end
        S_ISSUE:   w_next = S_WAIT;
        S_WAIT:    if (r_wcnt == '0) begin w_cap = 1'b1; w_next = S_SHOW; end
        S_SHOW:    if (w_prs0) w_next = S_LOAD_A;
        default:   w_next = S_LOAD_A;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_LOAD_A;
      r_rga   <= '0;
      r_rgb   <= '0;
      r_opt   <= '0;
      r_ena   <= 1'b0;
      r_res   <= '0;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_next;
      r_ena   <= (w_next == S_ISSUE);
      if (w_ld_a)  r_rga <= SW;
      if (w_ld_b)  r_rgb <= SW;
      if (w_ld_op) r_opt <= SW[OP_W-1:0];
      if (w_cap)   r_res <= RGZ;
      if (r_state == S_ISSUE) begin
        r_wcnt <= WCNT_W'(WAIT_CYC - 1);
      end else if ((r_state == S_WAIT) && (r_wcnt != '0)) begin
        r_wcnt <= r_wcnt - 1'b1;
      end
    end
  end

  assign RGA   = r_rga;
  assign RGB   = r_rgb;
  assign OPT   = r_opt;
  assign ENA   = r_ena;
  assign RES   = r_res;
  assign STATE = r_state;

endmodule
